// File: rtl/divider_pkg.sv
// Shared constants for the divider family: FSM encoding and default widths.
package divider_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DIV_N = 8;
  localparam int DIV_M = 4;
endpackage

// File: rtl/divider_seq_ctrl_if.sv
// Operand/result handshake bundle for the sequential divider.
interface divider_seq_ctrl_if #(parameter int N = 8, parameter int M = 4);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] dividend;
  logic [M-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] quotient;
  logic [M-1:0] remainder;
  logic         div_zero;
  logic         busy;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero, busy
  );
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero, busy
  );
endinterface

// File: rtl/divider_step.sv
// One restoring-division step: shift in a dividend bit, conditionally subtract.
module divider_step #(parameter int M = 4) (
  input  logic [M-1:0] rem_i,
  input  logic         bit_i,
  input  logic [M-1:0] divisor_i,
  output logic [M-1:0] rem_o,
  output logic         q_o
);
  logic [M:0] t;

  always_comb begin
    t     = {rem_i, bit_i};
    q_o   = (t >= {1'b0, divisor_i});
    // After a successful subtract the result is below the divisor, so M bits hold it;
    // when no subtract happens t < divisor, so its top bit is zero.
    rem_o = q_o ? M'(t - {1'b0, divisor_i}) : t[M-1:0];
  end
endmodule

// File: rtl/divider_seq_ctrl.sv
// Iterative restoring divider: one quotient bit per cycle, valid/ready on both sides.
module divider_seq_ctrl
  import divider_pkg::*;
#(
  parameter int N = DIV_N,
  parameter int M = DIV_M
) (
  input  logic             clk,
  input  logic             rst_n,
  divider_seq_ctrl_if.slave bus
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_e         state_q, state_d;
  logic [N-1:0]   dsr_q, dsr_d;
  logic [N-1:0]   quo_q, quo_d;
  logic [M-1:0]   dvs_q, dvs_d;
  logic [M-1:0]   rem_q, rem_d;   // partial remainder; the extra compare bit lives only in the step
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           dz_q, dz_d;
  logic [M-1:0]   step_rem;
  logic           step_q;

  divider_step #(.M(M)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dsr_q[N-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  always_comb begin
    state_d = state_q;
    dsr_d   = dsr_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          dsr_d = bus.dividend;
          dvs_d = bus.divisor;
          rem_d = '0;
          cnt_d = CW'(N - 1);
          if (bus.divisor == '0) begin
            quo_d   = '1;
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            quo_d   = '0;
            dz_d    = 1'b0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = {quo_q[N-2:0], step_q};
        dsr_d = {dsr_q[N-2:0], 1'b0};
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dsr_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dsr_q   <= dsr_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == CALC) || (state_q == DONE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.div_zero  = dz_q;
endmodule

// File: tb/tb_divider_seq_ctrl.sv
// Bench for divider_seq_ctrl: vector table, handshake corner sequences, random vs. arithmetic model.
module tb_divider_seq_ctrl;
  localparam int N = 8;
  localparam int M = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  divider_seq_ctrl_if #(.N(N), .M(M)) bus();

  divider_seq_ctrl #(.N(N), .M(M)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int pass_cnt = 0;
  int tot_cnt  = 0;

  typedef struct {
    logic [N-1:0] a;
    logic [M-1:0] b;
    logic [N-1:0] q;
    logic [M-1:0] r;
    logic         dz;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  // Reference: plain integer division; zero divisor saturates the quotient.
  task automatic model(input int a, input int b, output int q, output int r, output int dz);
    if (b == 0) begin q = (1 << N) - 1; r = 0; dz = 1; end
    else        begin q = a / b;        r = a % b; dz = 0; end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present operands, wait for accept, count edges to out_valid, check, then hand shake out.
  task automatic do_op(input string nm, input int a, input int b, input int eq, input int er,
                       input int edz, input int elat, input int stall);
    int n;
    int lat;
    bus.dividend = N'(a);
    bus.divisor  = M'(b);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    n = 0;
    while (!bus.in_ready && n < 100) begin tick(); n++; end
    chk({nm, "_accept_to"}, 32'(n < 100), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.dividend = 8'hA5;
    bus.divisor  = 4'h3;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin tick(); lat++; end
    chk({nm, "_lat"}, 32'(lat), 32'(elat));
    for (int s = 0; s < stall; s++) tick();
    chk({nm, "_q"}, 32'(bus.quotient), 32'(eq));
    chk({nm, "_r"}, 32'(bus.remainder), 32'(er));
    chk({nm, "_dz"}, 32'(bus.div_zero), 32'(edz));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({nm, "_ov_clr"}, 32'(bus.out_valid), 32'd0);
    chk({nm, "_rdy"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int n;
    int q, r, dz;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;

    // Reset state
    #12;
    chk("rst_ov",   32'(bus.out_valid), 32'd0);
    chk("rst_q",    32'(bus.quotient),  32'd0);
    chk("rst_r",    32'(bus.remainder), 32'd0);
    chk("rst_dz",   32'(bus.div_zero),  32'd0);
    chk("rst_busy", 32'(bus.busy),      32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_rdy", 32'(bus.in_ready), 32'd1);

    // Table-driven vectors; expected values worked out by hand.
    vecs.push_back('{a: 8'd200, b: 4'd7,  q: 8'd28,  r: 4'd4, dz: 1'b0, lat: 8});
    vecs.push_back('{a: 8'd5,   b: 4'd9,  q: 8'd0,   r: 4'd5, dz: 1'b0, lat: 8});
    vecs.push_back('{a: 8'd255, b: 4'd15, q: 8'd17,  r: 4'd0, dz: 1'b0, lat: 8});
    vecs.push_back('{a: 8'd255, b: 4'd1,  q: 8'd255, r: 4'd0, dz: 1'b0, lat: 8});
    // Zero divisor goes straight to DONE on the accept edge.
    vecs.push_back('{a: 8'd100, b: 4'd0,  q: 8'hFF,  r: 4'd0, dz: 1'b1, lat: 0});
    vecs.push_back('{a: 8'd0,   b: 4'd5,  q: 8'd0,   r: 4'd0, dz: 1'b0, lat: 8});
    vecs.push_back('{a: 8'd14,  b: 4'd15, q: 8'd0,   r: 4'd14, dz: 1'b0, lat: 8});
    vecs.push_back('{a: 8'd128, b: 4'd3,  q: 8'd42,  r: 4'd2, dz: 1'b0, lat: 8});
    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), int'(vecs[i].a), int'(vecs[i].b), int'(vecs[i].q),
            int'(vecs[i].r), int'(vecs[i].dz), vecs[i].lat, 0);

    // Back-pressure: result held, new operands ignored while busy.
    bus.dividend = 8'd200; bus.divisor = 4'd7; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 100) begin tick(); n++; end
    chk("bp_lat", 32'(n), 32'd8);
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = c[0];
      bus.dividend = 8'd99; bus.divisor = 4'd2;
      tick();
      chk("bp_ov",  32'(bus.out_valid), 32'd1);
      chk("bp_q",   32'(bus.quotient),  32'd28);
      chk("bp_r",   32'(bus.remainder), 32'd4);
      chk("bp_rdy", 32'(bus.in_ready),  32'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bp_rdy_after", 32'(bus.in_ready), 32'd1);
    chk("bp_ov_after",  32'(bus.out_valid), 32'd0);
    tick(); tick();
    chk("bp_no_sample", 32'(bus.busy), 32'd0);

    // Back-to-back with in_valid and out_ready held high.
    bus.dividend = 8'd60; bus.divisor = 4'd6;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick();
    chk("b2b_busy0", 32'(bus.busy), 32'd1);
    bus.dividend = 8'd61;
    n = 0;
    while (!bus.out_valid && n < 100) begin tick(); n++; end
    chk("b2b_lat0", 32'(n), 32'd8);
    chk("b2b_q0", 32'(bus.quotient), 32'd10);
    chk("b2b_r0", 32'(bus.remainder), 32'd0);
    tick();
    chk("b2b_rdy", 32'(bus.in_ready), 32'd1);
    tick();
    chk("b2b_busy1", 32'(bus.busy), 32'd1);
    n = 0;
    while (!bus.out_valid && n < 100) begin tick(); n++; end
    chk("b2b_lat1", 32'(n), 32'd8);
    chk("b2b_q1", 32'(bus.quotient), 32'd10);
    chk("b2b_r1", 32'(bus.remainder), 32'd1);
    bus.in_valid = 1'b0;
    tick();
    bus.out_ready = 1'b0;
    chk("b2b_done", 32'(bus.out_valid), 32'd0);

    // Reset during CALC discards the operation.
    bus.dividend = 8'd200; bus.divisor = 4'd7; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("mr_ov",   32'(bus.out_valid), 32'd0);
    chk("mr_q",    32'(bus.quotient),  32'd0);
    chk("mr_r",    32'(bus.remainder), 32'd0);
    chk("mr_dz",   32'(bus.div_zero),  32'd0);
    chk("mr_busy", 32'(bus.busy),      32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mr_rdy", 32'(bus.in_ready), 32'd1);
    n = 0;
    for (int c = 0; c < 12; c++) begin tick(); if (bus.out_valid) n++; end
    chk("mr_no_ov", 32'(n), 32'd0);
    do_op("mr_9_3", 9, 3, 3, 0, 0, 8, 0);

    // Random: every 4-bit divisor against random dividends.
    for (int i = 0; i < 48; i++) begin
      int a, b;
      a = int'($urandom_range(0, 255));
      b = i % 16;
      model(a, b, q, r, dz);
      do_op($sformatf("rnd%0d_%0d_%0d", i, a, b), a, b, q, r, dz, (b == 0) ? 0 : N,
            int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
